// File: rtl/button_debounce_req.sv
// Button conditioner: 2-FF sync, debounce FSM, rising-edge pulse and a held load request.
// Latency: btn_level follows btn_in DEBOUNCE_CYCLES+2 edges after a change; load_req holds until a tick consumes it.
module button_debounce_req #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic btn_in,
    input  logic tick,
    output logic btn_level,
    output logic btn_rise,
    output logic load_req,
    output logic req_overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 1 of the encoding is the debounced level, so btn_level comes straight off a flop.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CHK_HI = 2'b01,
        HELD   = 2'b10,
        CHK_LO = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             req_q, req_d;
    logic             ovr_q, ovr_d;
    logic             btn_b;

    assign btn_b = btn_in ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            req_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            s1_q    <= btn_b;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            req_q   <= req_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        case (state_q)
            IDLE, CHK_HI: begin
                if (s2_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = CHK_HI;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HELD, CHK_LO: begin
                if (!s2_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        state_d = CHK_LO;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new press outranks a tick consuming the previous request.
        if (rise_d) begin
            req_d = 1'b1;
        end else if (tick && req_q) begin
            req_d = 1'b0;
        end else begin
            req_d = req_q;
        end
        ovr_d = rise_d && req_q && !tick;
    end

    assign btn_level   = state_q[1];
    assign btn_rise    = rise_q;
    assign load_req    = req_q;
    assign req_overrun = ovr_q;

endmodule

// File: tb/tb_button_debounce_req.sv
// Scoreboarded bench: two instances (active-high and active-low) against a sliding-window reference model.
module tb_button_debounce_req;

    localparam int D = 4;

    logic clk_50M = 1'b0;
    logic rst_n;
    logic btn_in;
    logic tick;
    logic lvl0, rise0, req0, ovr0;
    logic lvl1, rise1, req1, ovr1;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    button_debounce_req #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .BTN_ACTIVE_LOW(1'b0)) dut0 (
        .clk_50M(clk_50M), .rst_n(rst_n), .btn_in(btn_in), .tick(tick),
        .btn_level(lvl0), .btn_rise(rise0), .load_req(req0), .req_overrun(ovr0)
    );

    button_debounce_req #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .BTN_ACTIVE_LOW(1'b1)) dut1 (
        .clk_50M(clk_50M), .rst_n(rst_n), .btn_in(btn_in), .tick(tick),
        .btn_level(lvl1), .btn_rise(rise1), .load_req(req1), .req_overrun(ovr1)
    );

    always #5 clk_50M = ~clk_50M;

    // Reference: level flips once the last D synchronised samples all disagree with it.
    typedef struct {
        bit          s1, s2, level, rise, req, ovr;
        int unsigned hist;
        int          nsamp;
    } mdl_t;

    mdl_t       m[2];
    logic [7:0] expq[$];
    logic [7:0] mon_e;
    logic [7:0] mon_a;

    function automatic void step(inout mdl_t x, input bit b, input bit tk, input bit rn);
        int unsigned mask;
        int unsigned last;
        bit          tog;
        bit          old_req;
        mask    = (32'd1 << D) - 1;
        tog     = 1'b0;
        old_req = x.req;
        if (!rn) begin
            x = '{default: 0};
        end else begin
            x.hist = {x.hist[30:0], x.s2};
            if (x.nsamp < 32) x.nsamp++;
            last = x.hist & mask;
            if (x.nsamp >= D && last == (x.level ? 32'd0 : mask)) tog = 1'b1;
            x.rise = tog && !x.level;
            if (tog) x.level = !x.level;
            if (x.rise) x.req = 1'b1;
            else if (tk && old_req) x.req = 1'b0;
            x.ovr = x.rise && old_req && !tk;
            x.s2 = x.s1;
            x.s1 = b;
        end
    endfunction

    task automatic cyc(input bit b, input bit t);
        btn_in = b;
        tick   = t;
        @(posedge clk_50M);
        #1;
        cyc_n++;
        step(m[0], b, t, rst_n);
        step(m[1], ~b, t, rst_n);
        expq.push_back({m[0].level, m[0].rise, m[0].req, m[0].ovr,
                        m[1].level, m[1].rise, m[1].req, m[1].ovr});
    endtask

    task automatic run(input bit b, input bit t, input int n);
        for (int i = 0; i < n; i++) cyc(b, t);
    endtask

    // Monitor: one expected entry per edge, compared away from the active edge.
    always @(negedge clk_50M) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            if (!rst_n) mon_e = 8'h00;
            mon_a = {lvl0, rise0, req0, ovr0, lvl1, rise1, req1, ovr1};
            total++;
            if (mon_a[7:4] != mon_e[7:4]) begin
                bad++;
                $display("FAIL hi_outputs cycle=%0d got(lvl,rise,req,ovr)=%b want=%b", cyc_n, mon_a[7:4], mon_e[7:4]);
            end
            total++;
            if (mon_a[3:0] != mon_e[3:0]) begin
                bad++;
                $display("FAIL lo_outputs cycle=%0d got(lvl,rise,req,ovr)=%b want=%b", cyc_n, mon_a[3:0], mon_e[3:0]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        btn_in = 1'b1;
        tick   = 1'b0;
        m[0]   = '{default: 0};
        m[1]   = '{default: 0};

        run(1, 0, 10);
        total++;
        if ({lvl0, rise0, req0, ovr0, lvl1, rise1, req1, ovr1} != 8'h00) begin
            bad++;
            $display("FAIL reset_state got=%b want=00000000", {lvl0, rise0, req0, ovr0, lvl1, rise1, req1, ovr1});
        end

        // Release reset with the button already pressed: count starts from zero.
        rst_n = 1'b1;
        run(1, 0, 10);
        cyc(1, 1);
        run(1, 0, 3);
        cyc(1, 1);
        run(1, 0, 2);

        // Asynchronous reset between edges while btn_level is high.
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({lvl0, rise0, req0, ovr0, lvl1, rise1, req1, ovr1} != 8'h00) begin
            bad++;
            $display("FAIL async_reset got=%b want=00000000", {lvl0, rise0, req0, ovr0, lvl1, rise1, req1, ovr1});
        end
        run(0, 0, 3);
        rst_n = 1'b1;
        run(0, 0, 8);

        // Clean press, long wait without tick, then consume.
        run(1, 0, 30);
        cyc(1, 1);
        run(1, 0, 3);
        cyc(1, 1);
        run(0, 0, 8);

        // Bounce on press.
        run(1, 0, 3);
        run(0, 0, 1);
        run(1, 0, 10);
        run(0, 0, 8);

        // Overrun: second press with the first request still pending.
        run(1, 0, 8);
        run(0, 0, 8);
        run(1, 0, 8);
        run(0, 0, 8);

        // Collision: tick at the same edge as the new rise.
        run(1, 0, 5);
        cyc(1, 1);
        run(1, 0, 4);
        run(0, 0, 8);
        cyc(0, 1);
        run(0, 0, 2);

        // Randomised bursts of levels and ticks.
        for (int r = 0; r < 300; r++) begin
            bit b;
            int len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) cyc(b, $urandom_range(0, 5) == 0);
        end

        @(negedge clk_50M);
        #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
